ctrl_unit_param: RTL and testbench

- Parametrised multi-cycle control sequencer for the accumulator CPU.
- Decodes the opcode latched from the instruction register.
- Steps fetch, address-assembly and execute states, and drives a named 16-bit control word to the datapath (PC, AR, DR, TR, IR, AC, ALU, memory).
- Over the previous generation it adds:
  - configurable opcode width;
  - configurable operand-address byte count;
  - memory wait states;
  - JPZ, JMP and HALT instructions;
  - an illegal-opcode trap.

---
 rtl/ctrl_pkg.sv | 85 ++++++++
 rtl/ctrl_decode.sv | 65 ++++++
 rtl/ctrl_unit_param.sv | 153 +++++++++++++++
 tb/tb_ctrl_unit_param.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the accumulator CPU control sequencer.
// Latency: n/a (constants, types and pure combinational helpers only).
// Backpressure: n/a.
//
// Holds the opcode values, the state encoding (also exported on state_dbg),
// the control-word bit positions and the ALU operation codes.
package ctrl_pkg;

  // Opcode values, low nibble of the IR opcode field.
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_READ  = 4'd1;
  localparam logic [3:0] OP_WRITE = 4'd2;
  localparam logic [3:0] OP_JPNZ  = 4'd3;
  localparam logic [3:0] OP_CLAC  = 4'd4;
  localparam logic [3:0] OP_ADD   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_RSH   = 4'd7;
  localparam logic [3:0] OP_LSH   = 4'd8;
  localparam logic [3:0] OP_INC   = 4'd9;
  localparam logic [3:0] OP_JPZ   = 4'd10;
  localparam logic [3:0] OP_JMP   = 4'd11;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // Sequencer states. Encodings 16..31 are unused and recover to TRAP.
  typedef enum logic [4:0] {
    ST_FETCH1 = 5'd0,
    ST_FETCH2 = 5'd1,
    ST_FETCH3 = 5'd2,
    ST_ADDR_A = 5'd3,
    ST_ADDR_B = 5'd4,
    ST_ADDR_C = 5'd5,
    ST_RD1    = 5'd6,
    ST_RD2    = 5'd7,
    ST_RD3    = 5'd8,
    ST_WR1    = 5'd9,
    ST_WR2    = 5'd10,
    ST_JMP1   = 5'd11,
    ST_SKIP   = 5'd12,
    ST_EXEC   = 5'd13,
    ST_HALT   = 5'd14,
    ST_TRAP   = 5'd15
  } state_e;

  // Control-word bit positions.
  localparam int CB_AR_FROM_PC  = 15;
  localparam int CB_PC_INC      = 14;
  localparam int CB_MEM_RD      = 13;
  localparam int CB_MEM_WR      = 12;
  localparam int CB_DR_FROM_MEM = 11;
  localparam int CB_IR_FROM_DR  = 10;
  localparam int CB_TR_SHIFT_DR = 9;
  localparam int CB_AR_FROM_TR  = 8;
  localparam int CB_PC_FROM_TR  = 7;
  localparam int CB_AC_FROM_DR  = 6;
  localparam int CB_DR_FROM_AC  = 5;
  localparam int CB_AC_CLR      = 4;
  localparam int CB_ALU_EN      = 3;

  // ALU operation codes carried in ctrl[2:0].
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_INC = 3'd2;
  localparam logic [2:0] ALU_RSH = 3'd3;
  localparam logic [2:0] ALU_LSH = 3'd4;

  // True for the opcodes that run one ALU cycle in EXEC.
  function automatic logic op_is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_RSH) ||
           (op == OP_LSH) || (op == OP_INC);
  endfunction

  // ALU operation selected by an ALU opcode.
  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    logic [2:0] res;
    case (op)
      OP_SUB:  res = ALU_SUB;
      OP_RSH:  res = ALU_RSH;
      OP_LSH:  res = ALU_LSH;
      OP_INC:  res = ALU_INC;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Control-word decoder: maps (state, latched opcode, memory ready) to the datapath strobes.
// Latency: purely combinational, zero cycles.
// Backpressure: mem_rdy low in a wait state suppresses pc_inc and dr_from_mem.
//
// Ports:
//   state_i  current sequencer state
//   op_i     opcode latched in FETCH3
//   mem_rdy  effective memory-ready (already forced high when waits are disabled)
//   ctrl_o   16-bit control word
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [3:0]  op_i,
  input  logic        mem_rdy,
  output logic [15:0] ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH1, ST_ADDR_A: begin
        ctrl_o[CB_AR_FROM_PC] = 1'b1;
        ctrl_o[CB_MEM_RD]     = 1'b1;
      end
      // The DR load and PC increment only commit on the cycle the memory
      // actually returns data, so a stalled read never double-increments PC.
      ST_FETCH2, ST_ADDR_B: begin
        ctrl_o[CB_MEM_RD]      = 1'b1;
        ctrl_o[CB_DR_FROM_MEM] = mem_rdy;
        ctrl_o[CB_PC_INC]      = mem_rdy;
      end
      ST_FETCH3: ctrl_o[CB_IR_FROM_DR]  = 1'b1;
      ST_ADDR_C: ctrl_o[CB_TR_SHIFT_DR] = 1'b1;
      ST_RD1: begin
        ctrl_o[CB_AR_FROM_TR] = 1'b1;
        ctrl_o[CB_MEM_RD]     = 1'b1;
      end
      ST_RD2: begin
        ctrl_o[CB_MEM_RD]      = 1'b1;
        ctrl_o[CB_DR_FROM_MEM] = mem_rdy;
      end
      ST_RD3: ctrl_o[CB_AC_FROM_DR] = 1'b1;
      ST_WR1: begin
        ctrl_o[CB_AR_FROM_TR] = 1'b1;
        ctrl_o[CB_DR_FROM_AC] = 1'b1;
      end
      ST_WR2:  ctrl_o[CB_MEM_WR]     = 1'b1;
      ST_JMP1: ctrl_o[CB_PC_FROM_TR] = 1'b1;
      // Skipping a not-taken jump's operand bytes only needs PC to advance.
      ST_SKIP: ctrl_o[CB_PC_INC] = 1'b1;
      ST_EXEC: begin
        if (op_i == OP_CLAC) begin
          ctrl_o[CB_AC_CLR] = 1'b1;
        end else if (op_is_alu(op_i)) begin
          ctrl_o[CB_ALU_EN] = 1'b1;
          ctrl_o[2:0]       = alu_op_of(op_i);
        end
      end
      // HALT, TRAP and any undefined encoding drive nothing.
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_unit_param.sv
// Multi-cycle control sequencer for the accumulator CPU (fetch, operand-address assembly, execute).
// Latency: ALU/CLAC 4, NOP 3, READ 6+3N, WRITE 5+3N, jump taken 4+3N, not taken 3+N cycles (N = ADDR_BYTES).
// Backpressure: every mem_ready=0 cycle in a memory wait state holds the sequencer for one cycle.
//
// Ports:
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   opcode      IR opcode field, sampled only in FETCH3
//   z_flag      accumulator-zero flag, sampled only in FETCH3
//   mem_ready   memory completes the current access this cycle
//   ctrl        16-bit datapath control word
//   halted      core is in HALT (sticky until reset)
//   illegal     core is in TRAP (sticky until reset)
//   state_dbg   current state encoding
module ctrl_unit_param
  import ctrl_pkg::*;
#(
  parameter int OP_W       = 4,  // >= 4; any set bit above bit 3 is illegal
  parameter int ADDR_BYTES = 2,  // operand-address bytes, 1..4
  parameter int WAIT_EN    = 1   // 0: mem_ready is ignored and treated as 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            z_flag,
  input  logic            mem_ready,
  output logic [15:0]     ctrl,
  output logic            halted,
  output logic            illegal,
  output logic [4:0]      state_dbg
);

  // Byte counter value on the final operand byte.
  localparam logic [1:0] CNT_LAST = 2'(ADDR_BYTES - 1);

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;

  logic        mem_rdy;
  logic        op_hi;
  logic        op_illegal;
  logic        last_byte;
  logic [15:0] dec_ctrl;

  assign mem_rdy = (WAIT_EN != 0) ? mem_ready : 1'b1;

  // Any bit of a wide opcode above the base nibble marks it illegal.
  always_comb begin
    op_hi = 1'b0;
    for (int i = 4; i < OP_W; i++) begin
      op_hi = op_hi | opcode[i];
    end
  end

  assign op_illegal = op_hi || (opcode[3:0] == 4'd12) ||
                      (opcode[3:0] == 4'd13) || (opcode[3:0] == 4'd14);

  assign last_byte = (cnt_q == CNT_LAST);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FETCH1: state_d = ST_FETCH2;
      ST_FETCH2: if (mem_rdy) state_d = ST_FETCH3;
      ST_FETCH3: begin
        op_d  = opcode[3:0];
        cnt_d = 2'd0;
        if (op_illegal) begin
          state_d = ST_TRAP;
        end else begin
          case (opcode[3:0])
            OP_HALT: state_d = ST_HALT;
            OP_NOP:  state_d = ST_FETCH1;
            OP_CLAC, OP_ADD, OP_SUB, OP_RSH, OP_LSH, OP_INC:
              state_d = ST_EXEC;
            // Not-taken jumps skip over their operand bytes without reading them.
            OP_JPNZ: state_d = z_flag ? ST_SKIP : ST_ADDR_A;
            OP_JPZ:  state_d = z_flag ? ST_ADDR_A : ST_SKIP;
            default: state_d = ST_ADDR_A;  // READ, WRITE, JMP
          endcase
        end
      end
      ST_ADDR_A: state_d = ST_ADDR_B;
      ST_ADDR_B: if (mem_rdy) state_d = ST_ADDR_C;
      ST_ADDR_C: begin
        cnt_d = cnt_q + 2'd1;
        if (last_byte) begin
          case (op_q)
            OP_READ:  state_d = ST_RD1;
            OP_WRITE: state_d = ST_WR1;
            default:  state_d = ST_JMP1;
          endcase
        end else begin
          state_d = ST_ADDR_A;
        end
      end
      ST_RD1:  state_d = ST_RD2;
      ST_RD2:  if (mem_rdy) state_d = ST_RD3;
      ST_RD3:  state_d = ST_FETCH1;
      ST_WR1:  state_d = ST_WR2;
      ST_WR2:  if (mem_rdy) state_d = ST_FETCH1;
      ST_JMP1: state_d = ST_FETCH1;
      ST_SKIP: begin
        cnt_d = cnt_q + 2'd1;
        if (last_byte) state_d = ST_FETCH1;
      end
      ST_EXEC: state_d = ST_FETCH1;
      ST_HALT: state_d = ST_HALT;
      ST_TRAP: state_d = ST_TRAP;
      // A corrupted state register parks the core in TRAP.
      default: state_d = ST_TRAP;
    endcase

    halted_d  = (state_d == ST_HALT);
    illegal_d = (state_d == ST_TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH1;
      op_q      <= 4'd0;
      cnt_q     <= 2'd0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  ctrl_decode u_decode (
    .state_i (state_q),
    .op_i    (op_q),
    .mem_rdy (mem_rdy),
    .ctrl_o  (dec_ctrl)
  );

  // Reset silences every strobe immediately, so an in-flight write cannot
  // keep mem_wr asserted while rst_n is low.
  assign ctrl      = rst_n ? dec_ctrl : 16'h0000;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ctrl_unit_param.sv
module tb_ctrl_unit_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  opcode_i  [4];
  logic        z_i       [4];
  logic        mr_i      [4];
  logic [15:0] ctrl_o    [4];
  logic        halted_o  [4];
  logic        illegal_o [4];
  logic [4:0]  st_o      [4];

  // Four configurations: N=1, N=2, N=4 with waits, and N=2 with waits disabled.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    ctrl_unit_param #(
      .OP_W       (5),
      .ADDR_BYTES ((g == 0) ? 1 : ((g == 2) ? 4 : 2)),
      .WAIT_EN    ((g == 3) ? 0 : 1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .opcode    (opcode_i[g]),
      .z_flag    (z_i[g]),
      .mem_ready (mr_i[g]),
      .ctrl      (ctrl_o[g]),
      .halted    (halted_o[g]),
      .illegal   (illegal_o[g]),
      .state_dbg (st_o[g])
    );
  end

  function automatic int nb(input int g);
    return (g == 0) ? 1 : ((g == 2) ? 4 : 2);
  endfunction

  function automatic bit we(input int g);
    return (g != 3);
  endfunction

  int nchk;
  int npass;

  task automatic chk(input string tag, input int g, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s[cfg%0d]: observed %h expected %h", tag, g, obs, exp);
  endtask

  // Reference model: one entry per non-stalled cycle of an instruction.
  typedef struct {
    logic [15:0] c;
    bit          w;   // memory wait state
  } step_t;

  step_t exp_q[$];

  function automatic step_t mk(input logic [15:0] c, input bit w);
    step_t s;
    s.c = c;
    s.w = w;
    return s;
  endfunction

  // kind: 0 = returns to fetch, 1 = halts, 2 = traps
  task automatic build(input int n, input logic [4:0] opc, input bit z, output int kind);
    bit taken;
    bit addressed;
    exp_q.delete();
    exp_q.push_back(mk(16'hA000, 0));
    exp_q.push_back(mk(16'h6800, 1));
    exp_q.push_back(mk(16'h0400, 0));
    kind = 0;
    taken = 1'b0;
    addressed = 1'b0;
    if (opc > 15 || (opc >= 12 && opc <= 14)) begin
      kind = 2;
    end else if (opc == 15) begin
      kind = 1;
    end else begin
      case (opc)
        5'd4:  exp_q.push_back(mk(16'h0010, 0));
        5'd5:  exp_q.push_back(mk(16'h0008, 0));
        5'd6:  exp_q.push_back(mk(16'h0009, 0));
        5'd7:  exp_q.push_back(mk(16'h000B, 0));
        5'd8:  exp_q.push_back(mk(16'h000C, 0));
        5'd9:  exp_q.push_back(mk(16'h000A, 0));
        5'd1, 5'd2, 5'd11: addressed = 1'b1;
        5'd3, 5'd10: begin
          taken = (opc == 3) ? !z : z;
          if (taken) addressed = 1'b1;
          else for (int b = 0; b < n; b++) exp_q.push_back(mk(16'h4000, 0));
        end
        default: ;
      endcase
      if (addressed) begin
        for (int b = 0; b < n; b++) begin
          exp_q.push_back(mk(16'hA000, 0));
          exp_q.push_back(mk(16'h6800, 1));
          exp_q.push_back(mk(16'h0200, 0));
        end
        if (opc == 1) begin
          exp_q.push_back(mk(16'h2100, 0));
          exp_q.push_back(mk(16'h2800, 1));
          exp_q.push_back(mk(16'h0040, 0));
        end else if (opc == 2) begin
          exp_q.push_back(mk(16'h0120, 0));
          exp_q.push_back(mk(16'h1000, 1));
        end else begin
          exp_q.push_back(mk(16'h0080, 0));
        end
      end
    end
  endtask

  task automatic drive(input int g, input bit mr, input bit fetch3, input logic [4:0] opc, input bit z);
    mr_i[g] = mr;
    if (fetch3) begin
      opcode_i[g] = opc;
      z_i[g]      = z;
    end else begin
      opcode_i[g] = 5'($urandom_range(0, 31));
      z_i[g]      = 1'($urandom_range(0, 1));
    end
  endtask

  // Entered and left at a falling edge. stalls < 0 picks 0..2 per wait state.
  task automatic run_instr(input int g, input logic [4:0] opc, input bit z,
                           input int stalls, input bit abort_wr2);
    int kind;
    int k;
    build(nb(g), opc, z, kind);
    for (int i = 0; i < exp_q.size(); i++) begin
      k = 0;
      if (exp_q[i].w && we(g)) k = (stalls < 0) ? $urandom_range(0, 2) : stalls;
      for (int s = 0; s < k; s++) begin
        drive(g, 1'b0, i == 2, opc, z);
        #1;
        chk("ctrl_stall", g, ctrl_o[g], exp_q[i].c & ~16'h4800);
        @(negedge clk);
      end
      if (abort_wr2 && exp_q[i].c == 16'h1000) begin
        drive(g, 1'b0, 1'b0, opc, z);
        #1;
        chk("wr2_ctrl", g, ctrl_o[g], 16'h1000);
        rst_n = 1'b0;
        #1;
        chk("abort_ctrl", g, ctrl_o[g], 16'h0000);
        chk("abort_state", g, {11'd0, st_o[g]}, 16'd0);
        return;
      end
      drive(g, we(g) ? 1'b1 : 1'($urandom_range(0, 1)), i == 2, opc, z);
      #1;
      chk("ctrl", g, ctrl_o[g], exp_q[i].c);
      chk("flags", g, {14'd0, halted_o[g], illegal_o[g]}, 16'd0);
      @(negedge clk);
    end
    if (kind == 0) begin
      chk("back_fetch1", g, {11'd0, st_o[g]}, 16'd0);
    end else begin
      for (int c = 0; c < 20; c++) begin
        drive(g, 1'($urandom_range(0, 1)), 1'b0, opc, z);
        #1;
        chk("sticky_ctrl", g, ctrl_o[g], 16'h0000);
        chk("sticky_flags", g, {14'd0, halted_o[g], illegal_o[g]},
            (kind == 1) ? 16'd2 : 16'd1);
        @(negedge clk);
      end
    end
  endtask

  // Asserts reset, checks the reset outputs, releases it at a falling edge.
  task automatic do_reset(input int g);
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl", g, ctrl_o[g], 16'h0000);
    chk("rst_flags", g, {14'd0, halted_o[g], illegal_o[g]}, 16'd0);
    chk("rst_state", g, {11'd0, st_o[g]}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nchk  = 0;
    npass = 0;
    rst_n = 1'b0;
    for (int g = 0; g < 4; g++) begin
      opcode_i[g] = 5'd0;
      z_i[g]      = 1'b0;
      mr_i[g]     = 1'b1;
    end

    for (int g = 0; g < 4; g++) begin
      do_reset(g);
      run_instr(g, 5'd5, 1'b0, 0, 1'b0);      // ADD, no waits
      run_instr(g, 5'd1, 1'b0, 2, 1'b0);      // READ with stalls
      run_instr(g, 5'd3, 1'b1, -1, 1'b0);     // JPNZ not taken
      run_instr(g, 5'd3, 1'b0, -1, 1'b0);     // JPNZ taken
      run_instr(g, 5'd10, 1'b0, -1, 1'b0);    // JPZ not taken
      run_instr(g, 5'd10, 1'b1, -1, 1'b0);    // JPZ taken
      run_instr(g, 5'd11, 1'b0, -1, 1'b0);    // JMP
      run_instr(g, 5'd2, 1'b0, -1, 1'b0);     // WRITE
      run_instr(g, 5'd4, 1'b0, -1, 1'b0);     // CLAC
      run_instr(g, 5'd0, 1'b0, -1, 1'b0);     // NOP
      for (int r = 0; r < 20; r++) begin
        run_instr(g, 5'($urandom_range(0, 11)), 1'($urandom_range(0, 1)), -1, 1'b0);
      end
      if (we(g)) begin
        run_instr(g, 5'd2, 1'b0, 1, 1'b1);    // reset lands inside WR2
        do_reset(g);
        run_instr(g, 5'd6, 1'b0, -1, 1'b0);
      end
      run_instr(g, 5'd13, 1'b0, -1, 1'b0);    // illegal low opcode
      do_reset(g);
      run_instr(g, 5'd21, 1'b0, -1, 1'b0);    // illegal upper bit
      do_reset(g);
      run_instr(g, 5'd15, 1'b0, -1, 1'b0);    // HALT
      do_reset(g);
      run_instr(g, 5'd9, 1'b0, -1, 1'b0);     // INC after leaving HALT
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
